// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between the
// instruction fetch (F) and data access (M) stages. Each access holds
// memAddr for LATENCY cycles, then captures memRData into the owner's
// result register and pulses the owner's valid for one cycle.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : ties go to the requester that was not granted last
//   undefined : fixed priority, M always wins ties
//
// state  | meaning
// IDLE   | no access in flight; arbitrate pending requests
// ACCESS | memory access for the latched owner, cnt counts held cycles
module mem_port_arbiter #(
  parameter int WIDTH            = 16,
  parameter int INSTRUCTIONWIDTH = 24,
  parameter int LATENCY          = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        fetchReq,
  input  logic [WIDTH-1:0]            fetchAddr,
  output logic                        fetchValid,
  output logic [INSTRUCTIONWIDTH-1:0] fetchData,
  input  logic                        dataReq,
  input  logic                        dataWe,
  input  logic [WIDTH-1:0]            dataAddr,
  input  logic [WIDTH-1:0]            dataWData,
  output logic                        dataValid,
  output logic [WIDTH-1:0]            dataRData,
  output logic                        memEnable,
  output logic                        memWe,
  output logic [WIDTH-1:0]            memAddr,
  output logic [WIDTH-1:0]            memWData,
  input  logic [INSTRUCTIONWIDTH-1:0] memRData,
  output logic                        stallF,
  output logic                        stallM
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             owner_m;
  logic             lat_we;
  logic [WIDTH-1:0] lat_addr;
  logic [WIDTH-1:0] lat_wdata;
  logic             done;
  logic             cand_f, cand_m;
  logic             grant, grant_m;
  logic             tie_to_m;

  // A requester whose valid is high is finishing, not asking again, so
  // the stall terms double as the "pending request" terms for arbitration.
  assign stallF = fetchReq & ~fetchValid;
  assign stallM = dataReq & ~dataValid;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_m;

  // Remember the most recent grant so a tie favours the other requester.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     last_m <= 1'b0;
    else if (grant) last_m <= grant_m;
  end

  assign tie_to_m = ~last_m;
`else
  assign tie_to_m = 1'b1;
`endif

  // Arbitration, next state and memory-side outputs.
  always_comb begin
    state_next = state;
    done       = (state == ACCESS) && (cnt == CNT_LAST);
    cand_f     = stallF;
    cand_m     = stallM;
    memEnable  = 1'b0;
    memWe      = 1'b0;
    memAddr    = '0;
    memWData   = '0;
    // The completing requester's req still belongs to the finished access.
    if (done) begin
      if (owner_m) cand_m = 1'b0;
      else         cand_f = 1'b0;
    end
    grant   = ((state == IDLE) || done) && (cand_f || cand_m);
    grant_m = cand_m && (!cand_f || tie_to_m);
    case (state)
      IDLE: begin
        if (grant) state_next = ACCESS;
      end
      ACCESS: begin
        memEnable = 1'b1;
        memWe     = (cnt == '0) && owner_m && lat_we;
        memAddr   = lat_addr;
        memWData  = lat_wdata;
        if (done) state_next = grant ? ACCESS : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Access latch, latency counter, result capture and valid pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      owner_m    <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      fetchValid <= 1'b0;
      dataValid  <= 1'b0;
      fetchData  <= '0;
      dataRData  <= '0;
    end else begin
      fetchValid <= 1'b0;
      dataValid  <= 1'b0;
      if (done) begin
        if (owner_m) begin
          dataValid <= 1'b1;
          if (!lat_we) dataRData <= memRData[WIDTH-1:0];
        end else begin
          fetchValid <= 1'b1;
          fetchData  <= memRData;
        end
      end
      if (grant) begin
        cnt       <= '0;
        owner_m   <= grant_m;
        lat_we    <= grant_m & dataWe;
        lat_addr  <= grant_m ? dataAddr : fetchAddr;
        lat_wdata <= grant_m ? dataWData : '0;
      end else if (state == ACCESS) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  // The owner must keep its request up until its access completes.
  always @(posedge clock) begin
    if (reset && (state == ACCESS))
      assert (owner_m ? dataReq : fetchReq);
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with LATENCY=2, default build.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fetchReq = 1'b0;
  logic [15:0] fetchAddr = '0;
  logic        fetchValid;
  logic [23:0] fetchData;
  logic        dataReq = 1'b0;
  logic        dataWe = 1'b0;
  logic [15:0] dataAddr = '0;
  logic [15:0] dataWData = '0;
  logic        dataValid;
  logic [15:0] dataRData;
  logic        memEnable;
  logic        memWe;
  logic [15:0] memAddr;
  logic [15:0] memWData;
  logic [23:0] memRData = '0;
  logic        stallF;
  logic        stallM;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.WIDTH(16), .INSTRUCTIONWIDTH(24), .LATENCY(2)) dut (
    .clock(clock), .reset(reset),
    .fetchReq(fetchReq), .fetchAddr(fetchAddr),
    .fetchValid(fetchValid), .fetchData(fetchData),
    .dataReq(dataReq), .dataWe(dataWe), .dataAddr(dataAddr),
    .dataWData(dataWData), .dataValid(dataValid), .dataRData(dataRData),
    .memEnable(memEnable), .memWe(memWe), .memAddr(memAddr),
    .memWData(memWData), .memRData(memRData),
    .stallF(stallF), .stallM(stallM)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [8:0] exp_fv;
    logic [8:0] exp_en;
    exp_fv = 9'b0_1000_1000;
    exp_en = 9'b0_0110_0110;

    // Reset state
    #2;
    chk("rst_fetchValid", {31'd0, fetchValid}, 32'd0);
    chk("rst_dataValid",  {31'd0, dataValid},  32'd0);
    chk("rst_memEnable",  {31'd0, memEnable},  32'd0);
    chk("rst_memAddr",    {16'd0, memAddr},    32'd0);
    chk("rst_fetchData",  {8'd0, fetchData},   32'd0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();

    // Fetch only
    next_cycle();                                     // cycle 0
    fetchReq = 1'b1; fetchAddr = 16'h0010; memRData = 24'hABCDEF;
    #1;
    chk("f_c0_stallF", {31'd0, stallF}, 32'd1);
    chk("f_c0_memEnable", {31'd0, memEnable}, 32'd0);
    next_cycle(); #1;                                 // cycle 1
    chk("f_c1_memEnable", {31'd0, memEnable}, 32'd1);
    chk("f_c1_memAddr", {16'd0, memAddr}, 32'h0010);
    chk("f_c1_memWe", {31'd0, memWe}, 32'd0);
    chk("f_c1_stallF", {31'd0, stallF}, 32'd1);
    next_cycle(); #1;                                 // cycle 2
    chk("f_c2_fetchValid", {31'd0, fetchValid}, 32'd0);
    chk("f_c2_stallF", {31'd0, stallF}, 32'd1);
    next_cycle(); #1;                                 // cycle 3
    chk("f_c3_fetchValid", {31'd0, fetchValid}, 32'd1);
    chk("f_c3_fetchData", {8'd0, fetchData}, 32'hABCDEF);
    chk("f_c3_stallF", {31'd0, stallF}, 32'd0);
    chk("f_c3_memEnable", {31'd0, memEnable}, 32'd0);
    fetchReq = 1'b0;
    next_cycle(); #1;                                 // cycle 4
    chk("f_c4_fetchValid", {31'd0, fetchValid}, 32'd0);
    chk("f_c4_fetchData_hold", {8'd0, fetchData}, 32'hABCDEF);

    // Data write
    next_cycle();                                     // cycle 0
    dataReq = 1'b1; dataWe = 1'b1; dataAddr = 16'h0040; dataWData = 16'h1234;
    #1;
    chk("w_c0_stallM", {31'd0, stallM}, 32'd1);
    next_cycle(); #1;                                 // cycle 1
    chk("w_c1_memWe", {31'd0, memWe}, 32'd1);
    chk("w_c1_memAddr", {16'd0, memAddr}, 32'h0040);
    chk("w_c1_memWData", {16'd0, memWData}, 32'h1234);
    next_cycle(); #1;                                 // cycle 2
    chk("w_c2_memWe", {31'd0, memWe}, 32'd0);
    chk("w_c2_memEnable", {31'd0, memEnable}, 32'd1);
    chk("w_c2_dataValid", {31'd0, dataValid}, 32'd0);
    next_cycle(); #1;                                 // cycle 3
    chk("w_c3_dataValid", {31'd0, dataValid}, 32'd1);
    chk("w_c3_dataRData_keep", {16'd0, dataRData}, 32'd0);
    chk("w_c3_stallM", {31'd0, stallM}, 32'd0);
    dataReq = 1'b0; dataWe = 1'b0;
    next_cycle();

    // Data read
    next_cycle();                                     // cycle 0
    dataReq = 1'b1; dataWe = 1'b0; dataAddr = 16'h0008; memRData = 24'h00BEEF;
    next_cycle(); #1;                                 // cycle 1
    chk("r_c1_memAddr", {16'd0, memAddr}, 32'h0008);
    chk("r_c1_memWe", {31'd0, memWe}, 32'd0);
    next_cycle();                                     // cycle 2
    next_cycle(); #1;                                 // cycle 3
    chk("r_c3_dataValid", {31'd0, dataValid}, 32'd1);
    chk("r_c3_dataRData", {16'd0, dataRData}, 32'hBEEF);
    chk("r_c3_fetchData_keep", {8'd0, fetchData}, 32'hABCDEF);
    dataReq = 1'b0;
    next_cycle();

    // Tie: M first, F granted on M's completion edge
    next_cycle();                                     // cycle 0
    fetchReq = 1'b1; fetchAddr = 16'h0020;
    dataReq = 1'b1; dataAddr = 16'h0030; memRData = 24'h123456;
    #1;
    chk("t_c0_stallF", {31'd0, stallF}, 32'd1);
    chk("t_c0_stallM", {31'd0, stallM}, 32'd1);
    next_cycle(); #1;                                 // cycle 1
    chk("t_c1_memAddr", {16'd0, memAddr}, 32'h0030);
    next_cycle();                                     // cycle 2
    next_cycle(); #1;                                 // cycle 3
    chk("t_c3_dataValid", {31'd0, dataValid}, 32'd1);
    chk("t_c3_dataRData", {16'd0, dataRData}, 32'h3456);
    chk("t_c3_memEnable", {31'd0, memEnable}, 32'd1);
    chk("t_c3_memAddr", {16'd0, memAddr}, 32'h0020);
    chk("t_c3_fetchValid", {31'd0, fetchValid}, 32'd0);
    dataReq = 1'b0;
    next_cycle(); #1;                                 // cycle 4
    chk("t_c4_fetchValid", {31'd0, fetchValid}, 32'd0);
    chk("t_c4_stallF", {31'd0, stallF}, 32'd1);
    next_cycle(); #1;                                 // cycle 5
    chk("t_c5_fetchValid", {31'd0, fetchValid}, 32'd1);
    chk("t_c5_fetchData", {8'd0, fetchData}, 32'h123456);
    chk("t_c5_dataRData_keep", {16'd0, dataRData}, 32'h3456);
    fetchReq = 1'b0;
    next_cycle();

    // Reset pulse during ACCESS with cnt=1
    next_cycle();                                     // cycle 0
    fetchReq = 1'b1; fetchAddr = 16'h0050;
    next_cycle();                                     // cycle 1
    next_cycle(); #1;                                 // cycle 2
    chk("x_c2_memEnable_pre", {31'd0, memEnable}, 32'd1);
    reset = 1'b0;
    #1;
    chk("x_c2_memEnable_rst", {31'd0, memEnable}, 32'd0);
    chk("x_c2_memAddr_rst", {16'd0, memAddr}, 32'd0);
    #2;
    fetchReq = 1'b0;
    reset = 1'b1;
    next_cycle(); #1;                                 // cycle 3
    chk("x_c3_fetchValid", {31'd0, fetchValid}, 32'd0);
    chk("x_c3_memEnable", {31'd0, memEnable}, 32'd0);
    chk("x_c3_fetchData_cleared", {8'd0, fetchData}, 32'd0);
    next_cycle(); #1;                                 // cycle 4
    chk("x_c4_fetchValid", {31'd0, fetchValid}, 32'd0);

    // Back-to-back fetch with request held
    for (int c = 0; c <= 8; c++) begin
      next_cycle();
      if (c == 0) begin
        fetchReq = 1'b1; fetchAddr = 16'h0060; memRData = 24'h0F0F0F;
      end
      #1;
      chk($sformatf("b2b_c%0d_fetchValid", c), {31'd0, fetchValid}, {31'd0, exp_fv[c]});
      chk($sformatf("b2b_c%0d_memEnable", c), {31'd0, memEnable}, {31'd0, exp_en[c]});
      if (c == 7) fetchReq = 1'b0;
    end
    chk("b2b_fetchData", {8'd0, fetchData}, 32'h0F0F0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
